// File: rtl/pam4_upsampler_pkg.sv
// Shared TX-path types and the 4-PAM Gray mapper; the RX slicer reuses pam4_map.
package tx_pkg;

  localparam int OSR_DEF   = 4;
  localparam int A_LVL_DEF = 32768;
  localparam int SAMPLE_W  = 18;

  typedef logic [1:0]                 sym_t;
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // msb selects polarity, lsb selects inner (1) or outer (0) level
  function automatic sample_t pam4_map(input sym_t sym, input sample_t a_lvl);
    sample_t mag;
    mag = sym[0] ? a_lvl : sample_t'(3 * a_lvl);
    return sym[1] ? mag : -mag;
  endfunction

endpackage

// File: rtl/pam4_upsampler_if.sv
// Symbol valid/ready handshake into the upsampler.
interface pam4_upsampler_if;
  import tx_pkg::*;

  sym_t sym_in;
  logic sym_valid;
  logic sym_ready;

  modport master (output sym_in, output sym_valid, input sym_ready);
  modport slave  (input sym_in, input sym_valid, output sym_ready);

endinterface

// File: rtl/pam4_upsampler_sym_fifo2.sv
// Two-entry symbol FIFO with same-edge push and pop; payload storage is not reset.
module sym_fifo2
  import tx_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  sym_t       din,
  input  logic       pop,
  output sym_t       dout,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  sym_t       mem_q [2];
  sym_t       mem_d [2];
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_push, do_pop;

  assign full  = (cnt_q == 2'(DEPTH));
  assign empty = (cnt_q == 2'd0);
  assign dout  = mem_q[rd_q];
  assign count = cnt_q;

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    do_push = push && !full;
    do_pop  = pop && !empty;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = ~wr_q;
    end
    if (do_pop) begin
      rd_d = ~rd_q;
    end
    cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pam4_upsampler.sv
// 4-PAM symbol buffer, Gray mapper and zero-insertion upsampler feeding the TX RRC filter.
module pam4_upsampler
  import tx_pkg::*;
#(
  parameter int OSR        = OSR_DEF,
  parameter int A_LVL      = A_LVL_DEF,
  parameter int FIFO_DEPTH = 2,
  localparam int PW        = $clog2(OSR)
) (
  input  logic              clk,
  input  logic              reset,
  pam4_upsampler_if.slave   s,
  output sample_t           y_out,
  output logic              sym_strobe,
  output logic [PW-1:0]     phase,
  output logic              underflow
);

  localparam sample_t A_S = sample_t'(A_LVL);

  logic          fifo_full, fifo_empty;
  logic [1:0]    fifo_count;
  sym_t          fifo_dout;
  logic          push, pop, slot;

  logic [PW-1:0] phase_q, phase_d;
  sample_t       y_q, y_d;
  logic          strobe_q, strobe_d;
  logic          underflow_q, underflow_d;
  logic          first_slot_q, first_slot_d;

  // Ready comes from registered FIFO state only, never from sym_valid
  assign s.sym_ready = !reset && !fifo_full;
  assign push        = s.sym_valid && s.sym_ready;
  assign slot        = (phase_q == PW'(OSR - 1));
  assign pop         = slot && !fifo_empty;

  sym_fifo2 #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (s.sym_in),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A symbol pushed on an empty slot edge is stored, not bypassed: the slot reads pre-edge empty
  always_comb begin
    phase_d      = slot ? '0 : phase_q + PW'(1);
    y_d          = pop ? pam4_map(fifo_dout, A_S) : '0;
    strobe_d     = slot;
    first_slot_d = slot ? 1'b0 : first_slot_q;
    underflow_d  = underflow_q | (slot & fifo_empty & ~first_slot_q);
  end

  // Output stage: sample register, phase and flags
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q      <= '0;
      y_q          <= '0;
      strobe_q     <= 1'b0;
      underflow_q  <= 1'b0;
      first_slot_q <= 1'b1;
    end else begin
      phase_q      <= phase_d;
      y_q          <= y_d;
      strobe_q     <= strobe_d;
      underflow_q  <= underflow_d;
      first_slot_q <= first_slot_d;
    end
  end

  assign y_out      = y_q;
  assign sym_strobe = strobe_q;
  assign phase      = phase_q;
  assign underflow  = underflow_q;

  logic unused_count;
  assign unused_count = ^fifo_count;

endmodule

// File: tb/tb_pam4_upsampler.sv
// Randomized bench for pam4_upsampler against a queue-based symbol-period model.
module tb_pam4_upsampler;
  import tx_pkg::*;

  localparam int OSR = 4;

  logic       clk = 1'b0;
  logic       reset;
  sample_t    y_out;
  logic       sym_strobe;
  logic [1:0] phase;
  logic       underflow;

  always #5 clk = ~clk;

  pam4_upsampler_if bus ();

  pam4_upsampler #(
    .OSR (OSR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s          (bus),
    .y_out      (y_out),
    .sym_strobe (sym_strobe),
    .phase      (phase),
    .underflow  (underflow)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Amplitude per symbol value {msb,lsb}: 00,01,10,11
  int lvl [4] = '{-98304, -32768, 98304, 32768};

  int mq [$];
  int m_phase, m_y;
  bit m_strobe, m_uf, m_first, m_ok;
  bit m_take;
  int slot_log [$];
  int uf_log   [$];

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Model: one step per clock edge, symbols as a queue of at most two
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_phase  = 0;
      m_y      = 0;
      m_strobe = 0;
      m_uf     = 0;
      m_first  = 1;
      m_ok     = 1;
    end else if (m_ok) begin
      m_take = bus.sym_valid && (mq.size() < 2);
      if (m_phase == OSR - 1) begin
        m_strobe = 1;
        if (mq.size() > 0) m_y = lvl[mq.pop_front()];
        else begin
          m_y = 0;
          if (!m_first) m_uf = 1;
        end
        m_first = 0;
      end else begin
        m_strobe = 0;
        m_y      = 0;
      end
      if (m_take) mq.push_back(int'(bus.sym_in));
      m_phase = (m_phase + 1) % OSR;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("y_out", y_out, m_y);
      chk("sym_strobe", sym_strobe, m_strobe);
      chk("phase", phase, m_phase);
      chk("underflow", underflow, m_uf);
      chk("sym_ready", bus.sym_ready, (!reset && mq.size() < 2));
      if (sym_strobe === 1'b1) begin
        slot_log.push_back(y_out);
        uf_log.push_back(underflow);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic send(input logic [1:0] sv);
    bit ok, hs;
    ok = 0;
    bus.sym_valid = 1'b1;
    bus.sym_in    = sv;
    for (int i = 0; i < 64; i++) begin
      hs = bus.sym_ready;
      tick();
      if (hs) begin
        ok = 1;
        break;
      end
    end
    chk("send_accepted", ok, 1);
  endtask

  task automatic wait_strobes(input int n);
    int k;
    k = 0;
    while (slot_log.size() < n && k < 200) begin
      tick();
      k++;
    end
    chk("strobe_wait", (slot_log.size() >= n), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ps;
    int k;
    reset         = 1'b1;
    bus.sym_valid = 1'b1;
    bus.sym_in    = 2'b00;
    repeat (3) tick();
    chk("reset_ready_low", bus.sym_ready, 0);
    reset = 1'b0;
    slot_log.delete();
    uf_log.delete();
    #1;
    chk("ready_after_reset", bus.sym_ready, 1);

    // Mapping then a continuous random stream under backpressure
    send(2'b00);
    send(2'b01);
    send(2'b11);
    send(2'b10);
    for (int i = 0; i < 100; i++) send(2'($urandom_range(0, 3)));
    bus.sym_valid = 1'b0;
    chk("no_underflow_stream", underflow, 0);
    wait_strobes(4);
    if (slot_log.size() >= 4) begin
      chk("map_00", slot_log[0], -98304);
      chk("map_01", slot_log[1], -32768);
      chk("map_11", slot_log[2], 32768);
      chk("map_10", slot_log[3], 98304);
      chk("map_uf", uf_log[3], 0);
    end

    // Starve the FIFO, then resume: underflow must stay set
    repeat (16) tick();
    chk("underflow_set", underflow, 1);
    send(2'($urandom_range(0, 3)));
    send(2'($urandom_range(0, 3)));
    bus.sym_valid = 1'b0;
    repeat (8) tick();
    chk("underflow_sticky", underflow, 1);
    reset = 1'b1;
    repeat (2) tick();
    chk("underflow_reset", underflow, 0);
    reset = 1'b0;

    // Push on the slot edge of an empty FIFO
    repeat (6) tick();
    k = 0;
    while (phase !== 2'd3 && k < 8) begin
      tick();
      k++;
    end
    chk("pp_phase_found", phase, 3);
    slot_log.delete();
    uf_log.delete();
    ps            = 2'($urandom_range(0, 3));
    bus.sym_valid = 1'b1;
    bus.sym_in    = ps;
    tick();
    bus.sym_valid = 1'b0;
    wait_strobes(2);
    if (slot_log.size() >= 2) begin
      chk("pp_slot_empty", slot_log[0], 0);
      chk("pp_slot_uf", uf_log[0], 1);
      chk("pp_next_slot", slot_log[1], lvl[ps]);
    end

    // Reset at phase 2 with the FIFO full
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    bus.sym_valid = 1'b1;
    bus.sym_in    = 2'b10;
    k = 0;
    while (!(phase === 2'd2 && bus.sym_ready === 1'b0) && k < 40) begin
      bus.sym_in = 2'($urandom_range(0, 3));
      tick();
      k++;
    end
    chk("mid_full_found", bus.sym_ready, 0);
    reset         = 1'b1;
    bus.sym_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    slot_log.delete();
    uf_log.delete();
    wait_strobes(3);
    if (slot_log.size() >= 3) begin
      chk("mid_first_slot", slot_log[0], 0);
      chk("mid_first_uf", uf_log[0], 0);
      chk("mid_no_stale_1", slot_log[1], 0);
      chk("mid_no_stale_2", slot_log[2], 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pam4_upsampler.md
Name: pam4_upsampler

Overview:
Transmit-path stage directly upstream of the root-raised-cosine TX pulse-shaping filter. It accepts 2-bit 4-PAM symbols through a valid/ready handshake and buffers them in a 2-entry FIFO. Each symbol is Gray-mapped to a signed 1s17 amplitude and upsampled by OSR through zero insertion, giving one sample per clk. The y_out port drives the filter's 18-bit signed x_in directly.

Parameters:
OSR, 4, samples per symbol; legal values 2..16; phase counter width is clog2(OSR).
A_LVL, 32768, inner PAM level in 1s17 (0.25). The outer level is 3*A_LVL (98304 = 0.75). Both levels must be less than 2^17.
FIFO_DEPTH, 2, symbol buffer entries; fixed at 2 for this revision.

Ports:
clk  in  1  system clock, one output sample per cycle
reset  in  1  synchronous, active-high
sym_in  in  2  symbol bits {msb,lsb}
sym_valid  in  1  sym_in holds a valid symbol
sym_ready  out  1  block can accept a symbol this cycle
y_out  out  18  signed 1s17 upsampled sample, registered; feeds the TX filter x_in
sym_strobe  out  1  high for the cycle in which y_out carries a symbol sample (phase 0)
phase  out  clog2(OSR)  current sample phase of y_out, 0..OSR-1
underflow  out  1  sticky; set when a symbol slot finds the FIFO empty

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - y_out=0, phase=0, sym_strobe=0, underflow=0; FIFO is emptied.
  - While reset is high, sym_ready=0.
  - Reset asserted mid-symbol discards buffered symbols and the partial period. No partial output appears after reset.
- Handshake:
  - A transfer occurs on a rising edge where sym_valid && sym_ready.
  - sym_ready = !reset && (fifo_count < 2). It is combinational from registered state only and never depends on sym_valid.
  - When sym_ready=0, sym_in is ignored.
- Phase counter:
  - Free-running 0,1,...,OSR-1,0.
  - Its value equals the phase of the y_out value currently being presented.
- Symbol slot (pop):
  - On the edge where phase==OSR-1, the FIFO head is popped and registered into y_out as map(sym), with phase becoming 0 and sym_strobe=1.
  - On all other edges, y_out becomes 0 and sym_strobe=0.
- Gray map (msb,lsb): 00 -> -3*A_LVL, 01 -> -A_LVL, 11 -> +A_LVL, 10 -> +3*A_LVL. The result is sign-correct 18-bit two's complement, with no saturation needed.
- Empty at slot:
  - y_out=0 for the entire symbol period.
  - sym_strobe still pulses at phase 0.
  - underflow is set and stays set until reset.
  - Exception: the first slot after reset does not set underflow if the FIFO is empty. A first_slot flag is cleared at the first slot edge.
- Simultaneous push and pop on the same edge:
  - Both are performed and count is unchanged.
  - If count was 0, the pushed symbol is not bypassed to the slot. It is stored, the slot is treated as empty, and it is emitted at the next slot.
  - If count was 2, no push is possible because sym_ready=0.
- Latency: a symbol accepted at edge E with an empty FIFO appears on y_out at the first slot edge strictly after E. For count=1 at E, it appears one slot later.
- Throughput: one symbol per OSR cycles sustained. Two-entry buffering lets a producer with one cycle of ready-to-valid slack run without underflow.
- Width rule: y_out magnitude is at most 0.75. After the filter's internal >>1 and tap sums, the filter does not overflow.

Decomposition:
- Shared package tx_pkg holds:
  - OSR_DEF=4, A_LVL_DEF=32768, SAMPLE_W=18;
  - symbol typedef (2-bit) and sample typedef (signed 18-bit);
  - function pam4_map(sym, a_lvl) returning the sample. The RX slicer reuses this function.
- Sub-module sym_fifo2: a 2-entry synchronous FIFO with push/pop, count, full/empty, and same-edge push+pop. It is instantiated once; the mapper, counter and flags live in the top module.

Test Plan:
- Reset check: hold reset 3 cycles with sym_valid=1 -> sym_ready=0, y_out=0, phase=0, underflow=0 throughout; release -> sym_ready=1 the next cycle.
- Mapping, OSR=4: feed 00,01,11,10 back-to-back -> y_out slot samples -98304,-32768,+32768,+98304, each followed by three zeros; sym_strobe period is 4; underflow stays 0.
- Backpressure: hold sym_valid=1 continuously -> two accepts, then sym_ready toggles so exactly one accept occurs per 4 cycles, in the cycle after each slot edge; no symbol is lost or duplicated (scoreboard over 100 random symbols).
- Underflow: send one symbol, then stop -> that symbol is emitted, the next slot gives y_out=0 for 4 cycles and underflow=1 sticky; resuming input does not clear it, reset does.
- Push+pop with empty FIFO at the slot edge: assert valid exactly at phase==3 with count 0 -> that slot outputs 0 with underflow=1; the symbol appears at the following slot.
- Mid-symbol reset: assert reset at phase 2 with 2 symbols buffered -> after release, the first slot outputs 0, underflow stays 0, and the buffered symbols are never emitted.
